// File: rtl/parking_payment.sv
// -----------------------------------------------------------------------------
// parking_payment
//
// Converts a check-out parking duration into a fee, collects coins until the
// fee is covered, reports change and holds the exit gate open for a fixed
// number of clock cycles. A driver may cancel while paying and receives a
// refund of everything inserted. Only one transaction is in flight at a time.
//
// Fee = RATE per started UNIT-long block beyond the first GRACE time units.
//
// Ports
//   i_clk         system clock, rising edge
//   i_reset       synchronous, active-high reset
//   i_start       1-cycle checkout pulse, i_use_time valid with it
//   i_use_time    parking duration (11 bits)
//   i_coin_valid  1-cycle pulse, coin inserted
//   i_coin_value  coin value, valid with i_coin_valid
//   i_cancel      driver aborts the payment (honoured only while paying)
//   o_busy        high in any state other than IDLE
//   o_fee_due     computed fee, held until the next accepted start
//   o_paid        coins accumulated in the current transaction
//   o_change      change (after done) or refund amount (after refund)
//   o_gate_open   high while the exit gate is held open
//   o_done        1-cycle pulse when the gate closes and the FSM returns idle
//   o_refund      1-cycle pulse after a cancel; o_change holds the refund
//
// state | meaning
// IDLE  | waiting for a checkout pulse
// CALC  | one billing block added to the fee per cycle
// PAY   | accepting coins until the fee is covered, or cancel
// GATE  | exit gate held open for GATE_CYCLES cycles
// -----------------------------------------------------------------------------
module parking_payment #(
    parameter int GRACE       = 15,
    parameter int UNIT        = 60,
    parameter int RATE        = 20,
    parameter int FEE_W       = 14,
    parameter int GATE_CYCLES = 100
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [10:0]      i_use_time,
    input  logic             i_coin_valid,
    input  logic [7:0]       i_coin_value,
    input  logic             i_cancel,
    output logic             o_busy,
    output logic [FEE_W-1:0] o_fee_due,
    output logic [FEE_W-1:0] o_paid,
    output logic [FEE_W-1:0] o_change,
    output logic             o_gate_open,
    output logic             o_done,
    output logic             o_refund
);

    localparam int CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    localparam logic [10:0]      GRACE_V  = 11'(GRACE);
    localparam logic [10:0]      UNIT_V   = 11'(UNIT);
    localparam logic [FEE_W:0]   RATE_V   = (FEE_W+1)'(RATE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_PAY  = 2'd2,
        S_GATE = 2'd3
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [10:0]      r_rem,      w_rem_nxt;
    logic [FEE_W-1:0] r_fee_due,  w_fee_nxt;
    logic [FEE_W-1:0] r_paid,     w_paid_nxt;
    logic [FEE_W-1:0] r_change,   w_change_nxt;
    logic [CNT_W-1:0] r_gate_cnt, w_gate_cnt_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_refund,   w_refund_nxt;

    // Datapath helpers: all sums carry one extra bit so saturation is a
    // simple check of the carry-out.
    logic [FEE_W-1:0] w_coin_ext;
    logic [FEE_W:0]   w_pay_full;
    logic [FEE_W-1:0] w_pay_sum;
    logic [FEE_W:0]   w_ref_full;
    logic [FEE_W-1:0] w_ref_sum;
    logic [FEE_W:0]   w_fee_full;
    logic [FEE_W-1:0] w_fee_sum;
    logic [10:0]      w_rem_start;
    logic [10:0]      w_rem_step;

    assign w_coin_ext  = {{(FEE_W-8){1'b0}}, i_coin_value};

    assign w_pay_full  = {1'b0, r_paid} + {1'b0, w_coin_ext};
    assign w_pay_sum   = w_pay_full[FEE_W] ? '1 : w_pay_full[FEE_W-1:0];

    // Refund includes a coin dropped in the same cycle as the cancel.
    assign w_ref_full  = {1'b0, r_paid} +
                         (i_coin_valid ? {1'b0, w_coin_ext} : '0);
    assign w_ref_sum   = w_ref_full[FEE_W] ? '1 : w_ref_full[FEE_W-1:0];

    assign w_fee_full  = {1'b0, r_fee_due} + RATE_V;
    assign w_fee_sum   = w_fee_full[FEE_W] ? '1 : w_fee_full[FEE_W-1:0];

    assign w_rem_start = (i_use_time > GRACE_V) ? (i_use_time - GRACE_V) : '0;
    assign w_rem_step  = (r_rem > UNIT_V) ? (r_rem - UNIT_V) : '0;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_rem      <= '0;
            r_fee_due  <= '0;
            r_paid     <= '0;
            r_change   <= '0;
            r_gate_cnt <= '0;
            r_done     <= 1'b0;
            r_refund   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rem      <= w_rem_nxt;
            r_fee_due  <= w_fee_nxt;
            r_paid     <= w_paid_nxt;
            r_change   <= w_change_nxt;
            r_gate_cnt <= w_gate_cnt_nxt;
            r_done     <= w_done_nxt;
            r_refund   <= w_refund_nxt;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        w_state_nxt    = r_state;
        w_rem_nxt      = r_rem;
        w_fee_nxt      = r_fee_due;
        w_paid_nxt     = r_paid;
        w_change_nxt   = r_change;
        w_gate_cnt_nxt = r_gate_cnt;
        w_done_nxt     = 1'b0;
        w_refund_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_rem_nxt    = w_rem_start;
                    w_fee_nxt    = '0;
                    w_paid_nxt   = '0;
                    w_change_nxt = '0;
                    w_state_nxt  = S_CALC;
                end
            end

            S_CALC: begin
                if (r_rem == '0) begin
                    if (r_fee_due == '0) begin
                        // Within the grace period: open the gate directly.
                        w_gate_cnt_nxt = CNT_LOAD;
                        w_state_nxt    = S_GATE;
                    end else begin
                        w_state_nxt    = S_PAY;
                    end
                end else begin
                    w_fee_nxt = w_fee_sum;
                    w_rem_nxt = w_rem_step;
                end
            end

            S_PAY: begin
                if (i_cancel) begin
                    w_change_nxt = w_ref_sum;
                    w_refund_nxt = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (i_coin_valid) begin
                    w_paid_nxt = w_pay_sum;
                    if (w_pay_sum >= r_fee_due) begin
                        w_change_nxt   = w_pay_sum - r_fee_due;
                        w_gate_cnt_nxt = CNT_LOAD;
                        w_state_nxt    = S_GATE;
                    end
                end
            end

            S_GATE: begin
                // Counter runs CNT_LOAD..0, giving GATE_CYCLES open cycles.
                if (r_gate_cnt == '0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gate_cnt_nxt = r_gate_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_busy      = (r_state != S_IDLE);
    assign o_gate_open = (r_state == S_GATE);
    assign o_fee_due   = r_fee_due;
    assign o_paid      = r_paid;
    assign o_change    = r_change;
    assign o_done      = r_done;
    assign o_refund    = r_refund;

endmodule

// File: tb/tb_parking_payment.sv
// -----------------------------------------------------------------------------
// tb_parking_payment
//
// Directed bench for parking_payment. Expected transaction outcomes (fee,
// change, done-vs-refund, gate length, cycles spent before the gate) are
// pushed to a queue as the closing stimulus is driven and popped when the
// design reports done or refund.
// -----------------------------------------------------------------------------
module tb_parking_payment;

    localparam int FEE_W = 14;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [10:0]      use_time;
    logic             coin_valid;
    logic [7:0]       coin_value;
    logic             cancel;
    logic             busy;
    logic [FEE_W-1:0] fee_due;
    logic [FEE_W-1:0] paid;
    logic [FEE_W-1:0] change;
    logic             gate_open;
    logic             done;
    logic             refund;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int fee;
        int chg;
        int is_done;
        int gates;
        int pre;
    } exp_t;

    exp_t sb[$];

    parking_payment dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_start      (start),
        .i_use_time   (use_time),
        .i_coin_valid (coin_valid),
        .i_coin_value (coin_value),
        .i_cancel     (cancel),
        .o_busy       (busy),
        .o_fee_due    (fee_due),
        .o_paid       (paid),
        .o_change     (change),
        .o_gate_open  (gate_open),
        .o_done       (done),
        .o_refund     (refund)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent fee model: started blocks beyond grace, saturating.
    function automatic int model_blocks(input int ut);
        int rem;
        rem = (ut > 15) ? ut - 15 : 0;
        return (rem + 59) / 60;
    endfunction

    function automatic int model_fee(input int ut);
        int f;
        f = model_blocks(ut) * 20;
        return (f > 16383) ? 16383 : f;
    endfunction

    task automatic start_txn(input int ut);
        @(posedge clk); #1;
        start    = 1'b1;
        use_time = 11'(ut);
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    task automatic drop_coin(input int v);
        @(posedge clk); #1;
        coin_valid = 1'b1;
        coin_value = 8'(v);
        @(posedge clk); #1;
        coin_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},   int'(busy),      0);
        chk({tag, "_fee"},    int'(fee_due),   0);
        chk({tag, "_paid"},   int'(paid),      0);
        chk({tag, "_change"}, int'(change),    0);
        chk({tag, "_gate"},   int'(gate_open), 0);
        chk({tag, "_done"},   int'(done),      0);
        chk({tag, "_refund"}, int'(refund),    0);
    endtask

    // Waits for done/refund, counting gate-open and pre-gate busy cycles.
    // poke >= 0 pulses start at that sample to show it is ignored.
    task automatic wait_end(input string tag, input int poke);
        exp_t e;
        int   gates = 0;
        int   pre   = 0;
        int   seen  = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == poke) begin
                start    = 1'b1;
                use_time = 11'd10;
            end else if (i == poke + 1) begin
                start    = 1'b0;
            end
            if (done || refund) begin
                seen = 1;
                break;
            end
            if (gate_open) gates++;
            else if (busy) pre++;
        end
        start = 1'b0;
        chk({tag, "_ended"}, seen, 1);
        e = sb.pop_front();
        chk({tag, "_done"},   int'(done),    e.is_done);
        chk({tag, "_refund"}, int'(refund),  1 - e.is_done);
        chk({tag, "_change"}, int'(change),  e.chg);
        chk({tag, "_fee"},    int'(fee_due), e.fee);
        chk({tag, "_gates"},  gates,         e.gates);
        chk({tag, "_pre"},    pre,           e.pre);
        chk({tag, "_busy"},   int'(busy),    0);
        @(negedge clk);
        chk({tag, "_pulse_done"},   int'(done),      0);
        chk({tag, "_pulse_refund"}, int'(refund),    0);
        chk({tag, "_gate_low"},     int'(gate_open), 0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        use_time   = '0;
        coin_valid = 1'b0;
        coin_value = '0;
        cancel     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_zero("rst");

        // T1: within grace period, gate opens after a single CALC cycle
        sb.push_back('{fee: model_fee(10), chg: 0, is_done: 1, gates: 100,
                       pre: model_blocks(10) + 1});
        start_txn(10);
        wait_end("t1", -1);

        // T2: exactly one block, paid in two coins
        start_txn(75);
        repeat (2) @(posedge clk);
        #1;
        chk("t2_fee_after_calc", int'(fee_due), model_fee(75));
        drop_coin(10);
        chk("t2_paid1", int'(paid), 10);
        chk("t2_gate_wait", int'(gate_open), 0);
        sb.push_back('{fee: 20, chg: 0, is_done: 1, gates: 100, pre: 0});
        drop_coin(10);
        wait_end("t2", -1);

        // T3: one minute over, second block billed; overpay
        start_txn(76);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_fee", int'(fee_due), model_fee(76));
        sb.push_back('{fee: 40, chg: 10, is_done: 1, gates: 100, pre: 0});
        drop_coin(50);
        wait_end("t3", -1);
        chk("t3_change_hold", int'(change), 10);

        // Coin and cancel in IDLE have no effect
        drop_coin(20);
        chk("idle_coin_paid", int'(paid), 50);
        @(posedge clk); #1;
        cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        chk("idle_cancel_refund", int'(refund), 0);
        chk("idle_cancel_change", int'(change), 10);
        chk("idle_busy", int'(busy), 0);

        // T4: cancel with a coin in the same cycle refunds both
        start_txn(76);
        repeat (3) @(posedge clk);
        drop_coin(10);
        chk("t4_paid", int'(paid), 10);
        sb.push_back('{fee: 40, chg: 15, is_done: 0, gates: 0, pre: 0});
        @(posedge clk); #1;
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 8'd5;
        @(posedge clk); #1;
        cancel     = 1'b0;
        coin_valid = 1'b0;
        wait_end("t4", -1);

        // T5: maximum duration, 35 CALC cycles; start/coins ignored in CALC
        start_txn(2047);
        repeat (10) @(posedge clk);
        #1;
        start      = 1'b1;
        use_time   = 11'd10;
        coin_valid = 1'b1;
        coin_value = 8'd50;
        @(posedge clk); #1;
        start      = 1'b0;
        coin_valid = 1'b0;
        chk("t5_fee_mid_calc", int'(fee_due), 220);
        chk("t5_paid_calc_coin", int'(paid), 0);
        repeat (23) @(posedge clk);
        #1;
        chk("t5_fee", int'(fee_due), model_fee(2047));
        coin_valid = 1'b1;
        coin_value = 8'd255;
        @(posedge clk); #1;
        chk("t5_last_calc_coin", int'(paid), 0);
        @(posedge clk); #1;
        coin_valid = 1'b0;
        chk("t5_first_pay_coin", int'(paid), 255);
        start    = 1'b1;
        use_time = 11'd10;
        @(posedge clk); #1;
        start    = 1'b0;
        chk("t5_pay_start_fee", int'(fee_due), 680);
        chk("t5_pay_start_paid", int'(paid), 255);
        drop_coin(255);
        sb.push_back('{fee: 680, chg: 85, is_done: 1, gates: 100, pre: 0});
        drop_coin(255);
        wait_end("t5", 40);
        chk("t5_paid_final", int'(paid), 765);

        // T6a: reset during PAY
        start_txn(75);
        repeat (2) @(posedge clk);
        drop_coin(10);
        chk("t6_paid_pre", int'(paid), 10);
        pulse_reset();
        chk_zero("t6_pay");

        // T6b: reset during GATE
        start_txn(10);
        repeat (5) @(posedge clk);
        #1;
        chk("t6_gate_pre", int'(gate_open), 1);
        pulse_reset();
        chk_zero("t6_gate");
        repeat (3) @(posedge clk);
        #1;
        chk("t6_gate_stays_low", int'(gate_open), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
